// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier.
// Each CALC cycle performs one partial-product add (acc + masked multiplicand)
// through a WIDTH-bit ripple-carry adder and shifts {carry, sum, q} right by one.
// Operands enter over a valid/ready handshake in IDLE; the 2*WIDTH-bit product
// leaves over a valid/ready handshake in DONE.

module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    // Counter wide enough to hold WIDTH-1 with headroom.
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // WIDTH-bit ripple-carry adder; returns {carry_out, sum}.
    function automatic logic [WIDTH:0] rca_add(
        input logic [WIDTH-1:0] op_a,
        input logic [WIDTH-1:0] op_b,
        input logic             cin
    );
        logic [WIDTH-1:0] sum;
        logic             carry;
        carry = cin;
        sum   = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = op_a[i] ^ op_b[i] ^ carry;
            carry  = (op_a[i] & op_b[i]) | (carry & (op_a[i] ^ op_b[i]));
        end
        return {carry, sum};
    endfunction

    // State and datapath registers.
    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_mcand;
    logic [CNT_W-1:0]   r_cnt;

    // Registered handshake/status outputs.
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    // Adder interface.
    logic [WIDTH-1:0]   w_add_b;
    logic [WIDTH:0]     w_add_res;
    logic               w_add_cout;
    logic [WIDTH-1:0]   w_add_sum;
    logic               w_accept;

    // Operands are taken only while ready is presented, i.e. only in IDLE.
    assign w_accept   = in_valid && r_in_ready;

    // Partial product: add the multiplicand only when the current multiplier bit is set.
    assign w_add_b    = r_q[0] ? r_mcand : {WIDTH{1'b0}};
    assign w_add_res  = rca_add(r_acc, w_add_b, 1'b0);
    assign w_add_cout = w_add_res[WIDTH];
    assign w_add_sum  = w_add_res[WIDTH-1:0];

    // State register with asynchronous reset to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an unreachable encoding recovers to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_CALC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: load operands on accept, add-and-shift during CALC, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= {WIDTH{1'b0}};
            r_q     <= {WIDTH{1'b0}};
            r_mcand <= {WIDTH{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_mcand <= a;
                        r_q     <= b;
                        r_acc   <= {WIDTH{1'b0}};
                        r_cnt   <= {CNT_W{1'b0}};
                    end else begin
                        r_mcand <= r_mcand;
                        r_q     <= r_q;
                        r_acc   <= r_acc;
                        r_cnt   <= r_cnt;
                    end
                end
                ST_CALC: begin
                    // Right shift of {carry, sum, q}: the adder carry lands in acc MSB.
                    r_acc   <= {w_add_cout, w_add_sum[WIDTH-1:1]};
                    r_q     <= {w_add_sum[0], r_q[WIDTH-1:1]};
                    r_mcand <= r_mcand;
                    r_cnt   <= r_cnt + CNT_ONE;
                end
                ST_DONE: begin
                    // Product must stay stable through backpressure and after the handshake.
                    r_acc   <= r_acc;
                    r_q     <= r_q;
                    r_mcand <= r_mcand;
                    r_cnt   <= r_cnt;
                end
                default: begin
                    r_acc   <= r_acc;
                    r_q     <= r_q;
                    r_mcand <= r_mcand;
                    r_cnt   <= r_cnt;
                end
            endcase
        end
    end

    // Status outputs registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign product   = {r_acc, r_q};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier (WIDTH = 8).
// Inputs change and outputs are sampled 1 time unit after the rising edge.

module tb_shift_add_multiplier;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int n_checks;
    int n_failures;

    shift_add_multiplier #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance edges until out_valid is seen or the budget runs out.
    task automatic wait_out_valid(input int start, output int edges);
        edges = start;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    // Present one operand pair, drop in_valid after the accept edge, wait for DONE.
    // Returns the number of edges counted from (and including) the accept edge.
    task automatic do_op(input logic [7:0] op_a, input logic [7:0] op_b, output int edges);
        a        = op_a;
        b        = op_b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out_valid(1, edges);
    endtask

    int edges;
    int n_spurious;

    initial begin
        n_checks   = 0;
        n_failures = 0;
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = 8'h00;
        b          = 8'h00;

        // 1. Asynchronous reset asserted mid-cycle, checked before any clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("rst_in_ready",  in_ready,  1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_busy",      busy,      1'b0);
        check_eq("rst_product",   product,   16'h0000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 2. 0x0F * 0x0F with out_ready held high.
        out_ready = 1'b1;
        do_op(8'h0F, 8'h0F, edges);
        check_eq("op0f_latency",   edges,     32'd9);
        check_eq("op0f_out_valid", out_valid, 1'b1);
        check_eq("op0f_product",   product,   16'h00E1);
        check_eq("op0f_busy",      busy,      1'b1);
        @(posedge clk);
        #1;
        check_eq("op0f_ret_valid", out_valid, 1'b0);
        check_eq("op0f_ret_ready", in_ready,  1'b1);
        check_eq("op0f_ret_busy",  busy,      1'b0);
        check_eq("op0f_hold_prod", product,   16'h00E1);

        // 3. Carry path: 0xFF * 0xFF.
        do_op(8'hFF, 8'hFF, edges);
        check_eq("opff_latency", edges,   32'd9);
        check_eq("opff_product", product, 16'hFE01);
        @(posedge clk);
        #1;

        // 4. Backpressure with an ignored in_valid during DONE.
        out_ready = 1'b0;
        do_op(8'h12, 8'h34, edges);
        check_eq("bp_latency", edges,   32'd9);
        check_eq("bp_product", product, 16'h03A8);
        a        = 8'hFF;
        b        = 8'hFF;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_hold_prod",  product,   16'h03A8);
            check_eq("bp_hold_valid", out_valid, 1'b1);
            check_eq("bp_hold_ready", in_ready,  1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_rel_valid", out_valid, 1'b0);
        check_eq("bp_rel_ready", in_ready,  1'b1);
        check_eq("bp_rel_prod",  product,   16'h03A8);

        // 5. Back-to-back with in_valid held high throughout.
        a        = 8'h80;
        b        = 8'h02;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_eq("b2b_acc1_busy", busy, 1'b1);
        a = 8'h00;
        b = 8'hAB;
        wait_out_valid(1, edges);
        check_eq("b2b_r1_latency", edges,   32'd9);
        check_eq("b2b_r1_product", product, 16'h0100);
        @(posedge clk);
        #1;
        check_eq("b2b_hs_ready", in_ready,  1'b1);
        check_eq("b2b_hs_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        check_eq("b2b_acc2_busy",  busy,     1'b1);
        check_eq("b2b_acc2_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        wait_out_valid(1, edges);
        check_eq("b2b_r2_latency", edges,   32'd9);
        check_eq("b2b_r2_product", product, 16'h0000);
        @(posedge clk);
        #1;

        // 6. Reset pulse in the middle of CALC aborts the operation.
        a        = 8'h55;
        b        = 8'h55;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check_eq("abort_pre_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_ready",   in_ready,  1'b1);
        check_eq("abort_busy",    busy,      1'b0);
        check_eq("abort_valid",   out_valid, 1'b0);
        check_eq("abort_product", product,   16'h0000);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        n_spurious = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) n_spurious++;
        end
        check_eq("abort_no_result", n_spurious, 32'd0);
        do_op(8'h03, 8'h05, edges);
        check_eq("post_latency", edges,   32'd9);
        check_eq("post_product", product, 16'h000F);
        @(posedge clk);
        #1;
        check_eq("post_ret_ready", in_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
